// File: rtl/regf_serial_loader.sv
// Serial-to-parallel write sequencer for the register file.
// Accepts a bit stream over a valid/ready handshake, packs DATA_W bits per
// word and writes NUM_WORDS consecutive words starting at address 0 for every
// start command. busy covers the whole load; done pulses for one cycle at
// the end.
module regf_serial_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_WORDS = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              s_in,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_e,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr_cnt;

  // Insert one received bit into the partial word; bit order is fixed by
  // MSB_FIRST so that the first bit ends up at the chosen end of the word.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr,
                                                 input logic              b);
    if (MSB_FIRST) begin
      return {sr[DATA_W-2:0], b};
    end else begin
      return {b, sr[DATA_W-1:1]};
    end
  endfunction

  // Sequencer FSM; every output is a register loaded on the transition into
  // the state that owns it, so no output depends combinationally on inputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      addr_cnt <= '0;
      s_ready  <= 1'b0;
      wr_data  <= '0;
      wr_addr  <= '0;
      wr_e     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SHIFT;
            addr_cnt <= '0;
            bit_cnt  <= '0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_SHIFT: begin
          // s_valid low is a stall: nothing moves until the next valid bit.
          if (s_valid) begin
            shreg <= shift_in(shreg, s_in);
            if (bit_cnt == BIT_LAST) begin
              // Last bit of the word: present it to the register file next cycle.
              bit_cnt <= '0;
              state   <= ST_WRITE;
              s_ready <= 1'b0;
              wr_e    <= 1'b1;
              wr_data <= shift_in(shreg, s_in);
              wr_addr <= addr_cnt;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_WRITE: begin
          // The bit on s_in during this cycle is not consumed (s_ready is low).
          wr_e <= 1'b0;
          if (addr_cnt == ADDR_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            state    <= ST_SHIFT;
            s_ready  <= 1'b1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          wr_e    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
